// File: rtl/trace_probe_mc_pkg.sv
// trace_probe_pkg: shared types and constants for the trace_probe_mc slice.
//   state_e      - probe control states
//   HDR_MAGIC    - first byte of every dump
//   HDR_BYTES    - header length in bytes
//   entry_bytes  - bytes per packed trace entry for a given field layout
//   cp_idx_width - width of the checkpoint index field (never zero)
// Optional feature macro used by the slice: TRACE_PROBE_FILTER_EN.
package trace_probe_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    DRAIN = 3'd3,
    HDR   = 3'd4,
    XMIT  = 3'd5
  } state_e;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int         HDR_BYTES = 4;

  // Bytes needed to hold {ts, cp_idx, id, meta}, rounded up to whole bytes.
  function automatic int entry_bytes(input int ts_w, input int cp_w,
                                     input int id_w, input int meta_w);
    return (ts_w + cp_w + id_w + meta_w + 7) / 8;
  endfunction

  // A single-channel probe still carries a 1-bit index so the field exists.
  function automatic int cp_idx_width(input int num_cp);
    return (num_cp > 1) ? $clog2(num_cp) : 1;
  endfunction

endpackage

// File: rtl/trace_probe_mc_if.sv
// trace_probe_mc_if: byte-serial handshake towards the UART transmitter.
//   uart_tx_data  - byte to transmit (probe -> UART)
//   uart_tx_valid - byte valid       (probe -> UART)
//   uart_tx_ready - UART accepts     (UART -> probe)
// master: the probe side; slave: the UART side.
interface trace_probe_mc_if;

  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready;

  modport master (
    output uart_tx_data,
    output uart_tx_valid,
    input  uart_tx_ready
  );

  modport slave (
    input  uart_tx_data,
    input  uart_tx_valid,
    output uart_tx_ready
  );

endinterface

// File: rtl/trace_probe_mc_arbiter.sv
// trace_entry_arbiter: combinational front end of the capture path.
//   cp_en/cp_id/meta - raw checkpoint strobes, packed ids, shared metadata
//   ts               - current timestamp
//   drop_cnt         - current drop counter
//   cp_mask          - per-channel enable (only with TRACE_PROBE_FILTER_EN)
//   hit              - at least one enabled strobe this cycle
//   entry            - packed entry {ts, cp_idx, id, meta} LSB first, zero padded
//   drop_cnt_nx      - drop counter including this cycle's losers, saturating at 255
import trace_probe_pkg::*;

module trace_entry_arbiter #(
  parameter int NUM_CP     = 4,
  parameter int ID_WIDTH   = 6,
  parameter int META_WIDTH = 31,
  parameter int TS_WIDTH   = 16,
  parameter int CP_W       = cp_idx_width(NUM_CP),
  parameter int EW         = 8 * entry_bytes(TS_WIDTH, CP_W, ID_WIDTH, META_WIDTH)
) (
  input  logic [NUM_CP-1:0]          cp_en,
  input  logic [NUM_CP*ID_WIDTH-1:0] cp_id,
  input  logic [META_WIDTH-1:0]      meta,
  input  logic [TS_WIDTH-1:0]        ts,
  input  logic [7:0]                 drop_cnt,
`ifdef TRACE_PROBE_FILTER_EN
  input  logic [NUM_CP-1:0]          cp_mask,
`endif
  output logic                       hit,
  output logic [EW-1:0]              entry,
  output logic [7:0]                 drop_cnt_nx
);

  logic [NUM_CP-1:0]   req_s;
  logic [CP_W-1:0]     win_s;
  logic                found_s;
  logic [3:0]          loss_s;
  logic [ID_WIDTH-1:0] id_s;
  logic [8:0]          drop_sum_s;

`ifdef TRACE_PROBE_FILTER_EN
  // Masked channels vanish before arbitration, so they never write or drop.
  assign req_s = cp_en & cp_mask;
`else
  assign req_s = cp_en;
`endif

  // Lowest requesting index wins; every other requester is a loser.
  always_comb begin
    win_s   = {CP_W{1'b0}};
    found_s = 1'b0;
    loss_s  = 4'd0;
    for (int k = 0; k < NUM_CP; k++) begin
      if (req_s[k] && !found_s) begin
        found_s = 1'b1;
        win_s   = CP_W'(k);
      end else if (req_s[k]) begin
        loss_s = loss_s + 4'd1;
      end else begin
        loss_s = loss_s;
      end
    end
  end

  assign hit        = found_s;
  assign id_s       = cp_id[win_s * ID_WIDTH +: ID_WIDTH];
  assign entry      = EW'({meta, id_s, win_s, ts});
  assign drop_sum_s = {1'b0, drop_cnt} + {5'b00000, loss_s};
  assign drop_cnt_nx = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];

endmodule

// File: rtl/trace_probe_mc.sv
// trace_probe_mc: multi-checkpoint trace probe.
// Captures checkpoint events into a circular trace RAM (pre-trigger history
// plus a post-trigger window), then dumps a 4-byte header and the entries,
// oldest first, byte-serially over the uart handshake interface.
//   clk_in, rst_n_in          - clock, asynchronous active-low reset
//   arm_in/trigger_in/force_tx_in - capture control
//   cp_en_in/cp_id_in/meta_in - checkpoint strobes, packed ids, metadata
//   cp_mask_in                - channel mask (TRACE_PROBE_FILTER_EN only)
//   uart                      - trace_probe_mc_if.master byte stream
//   busy_out                  - high whenever the probe is not IDLE
// Optional feature macro: TRACE_PROBE_FILTER_EN.
import trace_probe_pkg::*;

module trace_probe_mc #(
  parameter int NUM_CP     = 4,
  parameter int ID_WIDTH   = 6,
  parameter int META_WIDTH = 31,
  parameter int TS_WIDTH   = 16,
  parameter int DEPTH      = 1024,
  parameter int POST_DEPTH = 512
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       arm_in,
  input  logic                       trigger_in,
  input  logic                       force_tx_in,
  input  logic [NUM_CP-1:0]          cp_en_in,
  input  logic [NUM_CP*ID_WIDTH-1:0] cp_id_in,
  input  logic [META_WIDTH-1:0]      meta_in,
`ifdef TRACE_PROBE_FILTER_EN
  input  logic [NUM_CP-1:0]          cp_mask_in,
`endif
  trace_probe_mc_if.master           uart,
  output logic                       busy_out
);

  localparam int CP_W        = cp_idx_width(NUM_CP);
  localparam int ENTRY_BYTES = entry_bytes(TS_WIDTH, CP_W, ID_WIDTH, META_WIDTH);
  localparam int EW          = 8 * ENTRY_BYTES;
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = $clog2(DEPTH + 1);
  localparam int PC_W        = $clog2(POST_DEPTH + 1);
  localparam int BI_W        = $clog2(ENTRY_BYTES + HDR_BYTES);

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [PC_W-1:0]  POST_LAST  = PC_W'(POST_DEPTH - 1);
  localparam logic [BI_W-1:0]  HDR_LAST   = BI_W'(HDR_BYTES - 1);
  localparam logic [BI_W-1:0]  ENTRY_LAST = BI_W'(ENTRY_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);

  state_e            state_r, state_nx_s;
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic              wrapped_r;
  logic [TS_WIDTH-1:0] ts_r;
  logic [7:0]        drop_cnt_r, drop_nx_s;
  logic [PC_W-1:0]   post_cnt_r;
  logic [CNT_W-1:0]  cnt_r, rem_r;
  logic [15:0]       cnt16_s;
  logic [BI_W-1:0]   byte_idx_r, byte_nx_s;
  logic [1:0]        lat_r;
  logic [EW-1:0]     entry_s, entry_r, q_r;
  logic [EW-1:0]     mem_r [DEPTH];
  logic              hit_s, capture_s, xfer_s;
  logic              valid_r, busy_r;
  logic [7:0]        data_r, hdr_byte_s, ent_byte_s;

  trace_entry_arbiter #(
    .NUM_CP     (NUM_CP),
    .ID_WIDTH   (ID_WIDTH),
    .META_WIDTH (META_WIDTH),
    .TS_WIDTH   (TS_WIDTH),
    .CP_W       (CP_W),
    .EW         (EW)
  ) u_arb (
    .cp_en       (cp_en_in),
    .cp_id       (cp_id_in),
    .meta        (meta_in),
    .ts          (ts_r),
    .drop_cnt    (drop_cnt_r),
`ifdef TRACE_PROBE_FILTER_EN
    .cp_mask     (cp_mask_in),
`endif
    .hit         (hit_s),
    .entry       (entry_s),
    .drop_cnt_nx (drop_nx_s)
  );

  assign capture_s = ((state_r == ARMED) || (state_r == POST)) && hit_s;
  assign xfer_s    = valid_r && uart.uart_tx_ready;
  assign byte_nx_s = byte_idx_r + BI_W'(1);
  assign cnt16_s   = 16'(cnt_r);
  assign ent_byte_s = entry_r[8 * int'(byte_nx_s) +: 8];

  // Header byte that follows the one currently on the bus.
  always_comb begin
    case (byte_nx_s)
      BI_W'(1): hdr_byte_s = cnt16_s[7:0];
      BI_W'(2): hdr_byte_s = cnt16_s[15:8];
      BI_W'(3): hdr_byte_s = drop_cnt_r;
      default:  hdr_byte_s = HDR_MAGIC;
    endcase
  end

  // Next-state logic; force_tx_in is checked before trigger_in on purpose.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (arm_in) state_nx_s = ARMED;
        else        state_nx_s = IDLE;
      end
      ARMED: begin
        if (force_tx_in)     state_nx_s = DRAIN;
        else if (trigger_in) state_nx_s = POST;
        else                 state_nx_s = ARMED;
      end
      POST: begin
        if (force_tx_in)                          state_nx_s = DRAIN;
        else if (hit_s && (post_cnt_r == POST_LAST)) state_nx_s = DRAIN;
        else                                      state_nx_s = POST;
      end
      DRAIN: state_nx_s = HDR;
      HDR: begin
        if (xfer_s && (byte_idx_r == HDR_LAST))
          state_nx_s = (cnt_r == {CNT_W{1'b0}}) ? IDLE : XMIT;
        else
          state_nx_s = HDR;
      end
      XMIT: begin
        if (xfer_s && (byte_idx_r == ENTRY_LAST) && (rem_r == CNT_W'(1)))
          state_nx_s = IDLE;
        else
          state_nx_s = XMIT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
    end
  end

  // Capture bookkeeping: timestamp, write pointer, wrap flag, drops, post count.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ts_r       <= {TS_WIDTH{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      wrapped_r  <= 1'b0;
      drop_cnt_r <= 8'd0;
      post_cnt_r <= {PC_W{1'b0}};
    end else begin
      if ((state_r == IDLE) && arm_in) begin
        ts_r       <= {TS_WIDTH{1'b0}};
        wr_ptr_r   <= {PTR_W{1'b0}};
        wrapped_r  <= 1'b0;
        drop_cnt_r <= 8'd0;
      end else if ((state_r == ARMED) || (state_r == POST)) begin
        ts_r <= ts_r + TS_WIDTH'(1);
        if (hit_s) begin
          drop_cnt_r <= drop_nx_s;
          if (wr_ptr_r == PTR_LAST) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            wrapped_r <= 1'b1;
          end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
          end
        end
      end
      if (state_r == ARMED)
        post_cnt_r <= {PC_W{1'b0}};
      else if ((state_r == POST) && hit_s)
        post_cnt_r <= post_cnt_r + PC_W'(1);
    end
  end

  // Trace RAM: write in the event cycle, registered read of rd_ptr_r.
  always_ff @(posedge clk_in) begin
    if (capture_s)
      mem_r[wr_ptr_r] <= entry_s;
    q_r <= mem_r[rd_ptr_r];
  end

  // Readout: header, then entries. lat_r spans the two-cycle RAM latency
  // (address settle -> q_r -> entry_r) after every read-pointer change.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      rem_r      <= {CNT_W{1'b0}};
      byte_idx_r <= {BI_W{1'b0}};
      lat_r      <= 2'd0;
      entry_r    <= {EW{1'b0}};
      valid_r    <= 1'b0;
      data_r     <= 8'd0;
    end else begin
      case (state_r)
        DRAIN: begin
          cnt_r      <= wrapped_r ? CNT_FULL : CNT_W'(wr_ptr_r);
          rem_r      <= wrapped_r ? CNT_FULL : CNT_W'(wr_ptr_r);
          rd_ptr_r   <= wrapped_r ? wr_ptr_r : {PTR_W{1'b0}};
          data_r     <= HDR_MAGIC;
          valid_r    <= 1'b1;
          byte_idx_r <= {BI_W{1'b0}};
          lat_r      <= 2'd0;
        end
        HDR: begin
          if (xfer_s) begin
            if (byte_idx_r == HDR_LAST) begin
              valid_r    <= 1'b0;
              byte_idx_r <= {BI_W{1'b0}};
              lat_r      <= 2'd0;
            end else begin
              byte_idx_r <= byte_nx_s;
              data_r     <= hdr_byte_s;
            end
          end
        end
        XMIT: begin
          if (!valid_r) begin
            if (lat_r == 2'd0) begin
              lat_r <= 2'd1;
            end else begin
              entry_r    <= q_r;
              data_r     <= q_r[7:0];
              valid_r    <= 1'b1;
              byte_idx_r <= {BI_W{1'b0}};
              lat_r      <= 2'd2;
            end
          end else if (xfer_s) begin
            if (byte_idx_r == ENTRY_LAST) begin
              valid_r    <= 1'b0;
              lat_r      <= 2'd0;
              byte_idx_r <= {BI_W{1'b0}};
              if (rem_r != CNT_W'(1)) begin
                rem_r    <= rem_r - CNT_W'(1);
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
              end
            end else begin
              byte_idx_r <= byte_nx_s;
              data_r     <= ent_byte_s;
            end
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign uart.uart_tx_valid = valid_r;
  assign uart.uart_tx_data  = data_r;
  assign busy_out           = busy_r;

endmodule

// File: doc/trace_probe_mc.md
Name: trace_probe_mc

Overview:
Parametrised multi-checkpoint trace probe, the successor to the two-checkpoint pipeline probe.
- Timestamps checkpoint events into a circular BRAM with pre-trigger history and a programmable post-trigger window.
- Then streams a header plus entries, oldest first, byte-serially to the UART transmitter.
- Sits beside the processor pipeline; the UART TX sits downstream.

Parameters:
- NUM_CP, 4, number of checkpoint channels (1..8).
- ID_WIDTH, 6, per-checkpoint instruction id width.
- META_WIDTH, 31, shared packet metadata width.
- TS_WIDTH, 16, timestamp counter width.
- DEPTH, 1024, entries in the trace BRAM (any value >= 4).
- POST_DEPTH, 512, entries captured after trigger (1..DEPTH).

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, asynchronous active-low reset.
- arm_in, input, 1, start circular capture (honoured in IDLE only).
- trigger_in, input, 1, begin post-trigger window (honoured in ARMED only).
- force_tx_in, input, 1, stop capture and transmit immediately (ARMED/POST).
- cp_en_in, input, NUM_CP, per-checkpoint event strobes.
- cp_id_in, input, NUM_CP*ID_WIDTH, packed ids; channel k at [k*ID_WIDTH +: ID_WIDTH].
- meta_in, input, META_WIDTH, metadata, logged only for the winning channel.
- uart_tx_data, output, 8, byte to transmit.
- uart_tx_valid, output, 1, byte valid.
- uart_tx_ready, input, 1, UART accepts byte.
- busy_out, output, 1, high in any state other than IDLE.

Behaviour:
- Entry layout, LSB first: {ts, cp_idx[$clog2(NUM_CP)], id, meta}, zero-padded to ENTRY_BYTES = ceil(width/8) bytes.
- Reset values (asynchronous, active while rst_n_in=0):
  - state=IDLE; wr_ptr, wrapped, ts, drop_cnt and post_cnt all 0.
  - uart_tx_valid=0, uart_tx_data=0, busy_out=0.
  - Reset mid-transmit aborts the transfer; valid falls at the reset assertion, not at a clock edge.
- States and transitions:
  - IDLE: arm_in -> ARMED. Entering ARMED clears ts, wr_ptr, wrapped and drop_cnt.
  - ARMED: every cycle with any cp_en_in bit set writes one entry. wr_ptr increments and wraps DEPTH-1 -> 0; the first wrap sets wrapped. trigger_in -> POST with post_cnt=0.
  - POST: capture continues and post_cnt counts writes. After POST_DEPTH writes -> DRAIN.
  - Early exit: force_tx_in in ARMED or POST -> DRAIN. force_tx_in beats trigger_in when both arrive in the same cycle.
  - DRAIN: no writes. Latches count = wrapped ? DEPTH : wr_ptr and rd_ptr = wrapped ? wr_ptr : 0. Count 0 -> header only.
  - HDR: sends 4 bytes: 0xA5, count[7:0], count[15:8], drop_cnt.
  - XMIT: sends ENTRY_BYTES bytes per entry, byte 0 first. rd_ptr wraps DEPTH-1 -> 0. After the last byte of entry count-1 -> IDLE.
- Arbitration:
  - Simultaneous strobes: lowest index wins.
  - Each losing strobe increments drop_cnt (8 bits, saturates at 255).
  - Strobes in IDLE, DRAIN, HDR or XMIT are ignored and not counted.
- Timestamp: free-running from ARMED entry, wraps modulo 2^TS_WIDTH. The written entry carries the ts of its event cycle.
- Write path: write issues in the event cycle; no write-path latency is visible externally.
- BRAM read latency is 2 cycles.
  - uart_tx_valid is low for 2 cycles after each rd_ptr change and on HDR -> XMIT entry.
  - The whole entry is registered once; bytes are muxed out of that register.
- Handshake:
  - A byte transfers when valid && ready.
  - uart_tx_data is stable while valid && !ready.
  - Valid never drops without a transfer, except on reset.
- Control inputs received in states where they are not honoured are ignored, including arm_in while busy_out=1.

Optional Feature:
- TRACE_PROBE_FILTER_EN defined:
  - Adds input cp_mask_in [NUM_CP], sampled every cycle.
  - Masked channels are treated as never strobed: no write, no arbitration, no drop count.
- Undefined: the port is absent and all channels are enabled.

Decomposition:
- Package trace_probe_pkg holds:
  - the state enum {IDLE, ARMED, POST, DRAIN, HDR, XMIT};
  - HDR_MAGIC=8'hA5 and HDR_BYTES=4;
  - function entry_bytes(ts, cp, id, meta widths).
- Sub-module trace_entry_arbiter contains:
  - priority select;
  - entry packing;
  - drop-count saturation;
  - mask gating, when TRACE_PROBE_FILTER_EN is defined.

Test Plan:
- NUM_CP=4, DEPTH=16, POST_DEPTH=8: arm, 5 single strobes, force_tx -> header A5 05 00 00, then 5 entries, ts ascending, oldest first.
- Wrap: arm, 20 strobes, trigger, 8 strobes -> count=16; first entry sent is strobe #13.
- cp_en_in=4'b1011 for 3 cycles -> 3 entries with cp_idx=0; drop_cnt byte=6. 300 such cycles saturates drop_cnt at FF.
- uart_tx_ready held low 10 cycles mid-entry -> data stable, no byte skipped or duplicated; total bytes = 4 + count*ENTRY_BYTES.
- trigger_in and force_tx_in in the same cycle -> immediate DRAIN, no post capture. arm_in during XMIT -> ignored.
- rst_n_in pulsed low mid-XMIT -> valid=0 at the reset assertion, state IDLE. A new arm then starts with drop_cnt=0 and ts=0.
